// File: rtl/matrix_storage_responder_pkg.sv
// Shared definitions for the matrix storage responder and its calculator-side users.
// Holds default widths, the clear-engine state encoding and the read latency.
package matrix_storage_responder_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   // The calculator's capture pipeline is built around this same latency.
   localparam int RD_LAT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/matrix_storage_responder_if.sv
// Read/write/clear bus between the calculator-side master and the storage responder.
interface matrix_storage_responder_if #(
   parameter int ADDR_W = matrix_storage_responder_pkg::ADDR_W_DEF,
   parameter int DATA_W = matrix_storage_responder_pkg::DATA_W_DEF
);

   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              clr_start;
   logic [ADDR_W-1:0] clr_base;
   logic [ADDR_W:0]   clr_len;
   logic              clr_busy;
   logic              clr_done;

   modport master (
      output rd_addr, we, waddr, wdata, clr_start, clr_base, clr_len,
      input  rd_data, clr_busy, clr_done
   );

   modport slave (
      input  rd_addr, we, waddr, wdata, clr_start, clr_base, clr_len,
      output rd_data, clr_busy, clr_done
   );

endinterface

// File: rtl/matrix_storage_responder_clear_engine.sv
// Region-clear engine: walks ptr from base for len words, yielding to external writes.
module storage_clear_engine
   import matrix_storage_responder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   input  logic              ext_we,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy,
   output logic              done
);

   clr_state_e        state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [ADDR_W:0]   cnt, cnt_n;
   logic [ADDR_W:0]   len_q, len_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         len_q <= len_n;
      end
   end

   // NOTE: every comb output gets a default first so no path holds a value (no latch).
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      len_n   = len_q;
      clr_we  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               len_n   = len;
               ptr_n   = base;
               cnt_n   = '0;
               state_n = (len == '0) ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            // An external write owns this edge; the clear simply waits a cycle.
            if (!ext_we) begin
               clr_we = 1'b1;
               ptr_n  = ptr + ADDR_W'(1);
               cnt_n  = cnt + (ADDR_W+1)'(1);
               if (cnt_n == len_q) state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign clr_addr = ptr;
   assign busy     = (state == CLEAR);
   assign done     = (state == DONE);

endmodule

// File: rtl/matrix_storage_responder.sv
// Matrix word store with 2-edge registered reads, single-word writes and a region-clear engine.
module matrix_storage_responder
   import matrix_storage_responder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input logic                      clk,
   input logic                      rst_n,
   matrix_storage_responder_if.slave bus
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] rd_data_q;

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   storage_clear_engine #(.ADDR_W(ADDR_W)) u_clear (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (bus.clr_start),
      .base     (bus.clr_base),
      .len      (bus.clr_len),
      .ext_we   (bus.we),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (bus.clr_busy),
      .done     (bus.clr_done)
   );

   // External write wins; the engine already stalls whenever bus.we is high.
   always_comb begin
      mem_we    = bus.we | clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
      if (bus.we) begin
         mem_waddr = bus.waddr;
         mem_wdata = bus.wdata;
      end
   end

   // NOTE: the storage array has no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         rd_data_q <= '0;
      end else begin
         addr_reg <= bus.rd_addr;
         // Write-first: a word committed on this same edge is returned directly.
         if (mem_we && (mem_waddr == addr_reg)) rd_data_q <= mem_wdata;
         else                                    rd_data_q <= mem[addr_reg];
      end
   end

   assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_matrix_storage_responder.sv
// Directed bench for matrix_storage_responder: reads, writes, bypass and region clears.
module tb_matrix_storage_responder;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   matrix_storage_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   matrix_storage_responder #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic write_word(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
      @(posedge clk);
      #1 bus.we = 1'b0;
   endtask

   task automatic read_word(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.rd_addr = a;
      @(posedge clk);
      @(posedge clk);
      #1 d = bus.rd_data;
   endtask

   task automatic test_reset();
      write_word(8'h00, 32'h0A0A_0001);
      write_word(8'h33, 32'h0B0B_0033);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.rd_addr   = 8'($urandom);
         bus.waddr     = 8'($urandom);
         bus.wdata     = $urandom;
         bus.clr_start = 1'($urandom);
         bus.clr_base  = 8'($urandom);
         bus.clr_len   = 9'($urandom);
      end
      #1;
      total++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", bus.rd_data); else passed++;
      total++; if (bus.clr_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.clr_busy); else passed++;
      total++; if (bus.clr_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.clr_done); else passed++;
      @(negedge clk);
      bus.clr_start = 1'b0;
      bus.rd_addr   = 8'h33;
      rst_n         = 1'b1;
      @(posedge clk); #1;
      // Address register restarts at 0, so the first edge still returns mem[0].
      total++; if (bus.rd_data !== 32'h0A0A_0001) $display("FAIL reset_lat_edge1 got %h want 0a0a0001", bus.rd_data); else passed++;
      @(posedge clk); #1;
      total++; if (bus.rd_data !== 32'h0B0B_0033) $display("FAIL reset_lat_edge2 got %h want 0b0b0033", bus.rd_data); else passed++;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      bus.rd_addr = 8'h33;
      bus.we = 1'b1; bus.waddr = 8'h10; bus.wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      bus.we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.rd_addr = 8'h10;
      @(posedge clk); #1;
      total++; if (bus.rd_data !== 32'h0B0B_0033) $display("FAIL wr_rd_edge3 got %h want 0b0b0033", bus.rd_data); else passed++;
      @(posedge clk); #1;
      total++; if (bus.rd_data !== 32'hDEAD_BEEF) $display("FAIL wr_rd_edge4 got %h want deadbeef", bus.rd_data); else passed++;
   endtask

   task automatic test_bypass();
      write_word(8'h05, 32'h1);
      @(negedge clk);
      bus.rd_addr = 8'h05;
      @(posedge clk);
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = 8'h05; bus.wdata = 32'h7;
      @(posedge clk); #1;
      bus.we = 1'b0;
      total++; if (bus.rd_data !== 32'h7) $display("FAIL bypass_same_edge got %h want 7", bus.rd_data); else passed++;
      @(posedge clk); #1;
      total++; if (bus.rd_data !== 32'h7) $display("FAIL bypass_after got %h want 7", bus.rd_data); else passed++;
   endtask

   task automatic test_clear_wrap();
      int busy_n = 0;
      int done_n = 0;
      logic [31:0] d;
      for (int i = 0; i < 10; i++) write_word(8'(250 + i), 32'hAAAA_AAAA);
      write_word(8'd100, 32'h0000_0100);
      @(negedge clk);
      bus.clr_start = 1'b1; bus.clr_base = 8'd250; bus.clr_len = 9'd8;
      @(posedge clk); #1;
      if (bus.clr_busy) busy_n++;
      if (bus.clr_done) done_n++;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.clr_start = 1'b0;
         bus.we = (c == 2); bus.waddr = 8'd100; bus.wdata = 32'h1234_5678;
         @(posedge clk); #1;
         if (bus.clr_busy) busy_n++;
         if (bus.clr_done) done_n++;
      end
      total++; if (busy_n != 9) $display("FAIL clr_wrap_busy got %0d want 9", busy_n); else passed++;
      total++; if (done_n != 1) $display("FAIL clr_wrap_done got %0d want 1", done_n); else passed++;
      for (int i = 0; i < 8; i++) begin
         read_word(8'(250 + i), d);
         total++; if (d !== 32'h0) $display("FAIL clr_wrap_zero[%0d] got %h want 0", 8'(250 + i), d); else passed++;
      end
      for (int i = 2; i < 4; i++) begin
         read_word(8'(i), d);
         total++; if (d !== 32'hAAAA_AAAA) $display("FAIL clr_wrap_keep[%0d] got %h want aaaaaaaa", i, d); else passed++;
      end
      read_word(8'd100, d);
      total++; if (d !== 32'h1234_5678) $display("FAIL clr_wrap_ext got %h want 12345678", d); else passed++;
   endtask

   task automatic test_zero_len_restart();
      int busy_n = 0;
      int done_n = 0;
      logic [31:0] d;
      write_word(8'd20, 32'hCCCC_0020);
      @(negedge clk);
      bus.clr_start = 1'b1; bus.clr_base = 8'd20; bus.clr_len = 9'd0;
      @(posedge clk); #1;
      total++; if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b1)
         $display("FAIL zero_len_first busy=%b done=%b want busy=0 done=1", bus.clr_busy, bus.clr_done); else passed++;
      @(negedge clk);
      bus.clr_start = 1'b0;
      @(posedge clk); #1;
      total++; if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0)
         $display("FAIL zero_len_second busy=%b done=%b want 0 0", bus.clr_busy, bus.clr_done); else passed++;
      read_word(8'd20, d);
      total++; if (d !== 32'hCCCC_0020) $display("FAIL zero_len_mem got %h want cccc0020", d); else passed++;

      for (int i = 40; i < 45; i++) write_word(8'(i), 32'hDDDD_0000 + 32'(i));
      @(negedge clk);
      bus.clr_start = 1'b1; bus.clr_base = 8'd40; bus.clr_len = 9'd4;
      @(posedge clk); #1;
      if (bus.clr_busy) busy_n++;
      if (bus.clr_done) done_n++;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         bus.clr_start = (c == 0); bus.clr_base = 8'd42; bus.clr_len = 9'd10;
         @(posedge clk); #1;
         if (bus.clr_busy) busy_n++;
         if (bus.clr_done) done_n++;
      end
      bus.clr_start = 1'b0;
      total++; if (busy_n != 4) $display("FAIL restart_busy got %0d want 4", busy_n); else passed++;
      total++; if (done_n != 1) $display("FAIL restart_done got %0d want 1", done_n); else passed++;
      for (int i = 40; i < 44; i++) begin
         read_word(8'(i), d);
         total++; if (d !== 32'h0) $display("FAIL restart_zero[%0d] got %h want 0", i, d); else passed++;
      end
      read_word(8'd44, d);
      total++; if (d !== 32'hDDDD_002C) $display("FAIL restart_keep got %h want dddd002c", d); else passed++;
   endtask

   task automatic test_reset_mid_clear();
      int busy_n = 0;
      int done_n = 0;
      logic [31:0] d;
      for (int i = 0; i < 16; i++) write_word(8'(i), 32'hE000_0000 + 32'(i));
      @(negedge clk);
      bus.clr_start = 1'b1; bus.clr_base = 8'd0; bus.clr_len = 9'd16;
      @(posedge clk);
      @(negedge clk);
      bus.clr_start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0)
         $display("FAIL midclr_in_reset busy=%b done=%b want 0 0", bus.clr_busy, bus.clr_done); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (bus.clr_busy) busy_n++;
         if (bus.clr_done) done_n++;
      end
      total++; if (busy_n != 0 || done_n != 0)
         $display("FAIL midclr_after busy_cycles=%0d done_pulses=%0d want 0 0", busy_n, done_n); else passed++;
      for (int i = 0; i < 16; i++) begin
         read_word(8'(i), d);
         total++;
         if (i < 5) begin
            if (d !== 32'h0) $display("FAIL midclr_zero[%0d] got %h want 0", i, d); else passed++;
         end else begin
            if (d !== 32'hE000_0000 + 32'(i))
               $display("FAIL midclr_keep[%0d] got %h want %h", i, d, 32'hE000_0000 + 32'(i));
            else passed++;
         end
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.rd_addr   = '0;
      bus.we        = 1'b0;
      bus.waddr     = '0;
      bus.wdata     = '0;
      bus.clr_start = 1'b0;
      bus.clr_base  = '0;
      bus.clr_len   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      test_reset();
      test_write_read();
      test_bypass();
      test_clear_wrap();
      test_zero_len_restart();
      test_reset_mid_clear();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/matrix_storage_responder.md
Name: matrix_storage_responder

Overview:
Storage-side responder for the calculator read/write interface. It holds the matrix word store and answers read-address requests with a fixed 2-edge latency, which matches the calculator's 2-stage capture pipeline. It also accepts single-word writes from the storage write mux. A built-in region-clear engine zeroes a contiguous block of words, for example when a matrix slot is freed.

Parameters:
ADDR_W, 8, word-address width; depth is 2**ADDR_W words.
DATA_W, 32, word width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
i_rd_addr  in  ADDR_W  read address request, sampled every edge.
o_rd_data  out  DATA_W  read data for the address sampled 2 edges earlier.
i_we  in  1  write enable, one word per cycle.
i_waddr  in  ADDR_W  write address.
i_wdata  in  DATA_W  write data.
i_clr_start  in  1  1-cycle pulse that starts a region clear.
i_clr_base  in  ADDR_W  first address to clear, sampled with i_clr_start.
i_clr_len  in  ADDR_W+1  number of words to clear (0..2**ADDR_W), sampled with i_clr_start.
o_clr_busy  out  1  high while the clear engine owns spare write slots.
o_clr_done  out  1  1-cycle pulse when a clear completes.

Behaviour:
- Reset (async, rst_n=0):
  - o_rd_data=0, o_clr_busy=0, o_clr_done=0.
  - Address pipeline register=0; clear FSM goes to IDLE.
  - Memory contents are not reset.
- Read path, 2 register stages:
  - Stage 1: at edge k, i_rd_addr is captured into the address register.
  - Stage 2: at edge k+1, mem[addr_reg] is captured into o_rd_data.
  - Reads are serviced every cycle, unconditionally, including during a clear.
- Write path: when i_we=1 at edge j, mem[i_waddr] <= i_wdata.
- Write-first bypass: if the stage-2 read at edge j targets the same address as a write committed at edge j (external or clear), o_rd_data takes the new data.
- Write priority at any edge: external write first, then clear write. At most one memory write per edge.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE:
    - On i_clr_start, latch base and len, set ptr=base, cnt=0, go to CLEAR, and assert o_clr_busy from the next cycle.
    - If len=0, go straight to DONE.
  - CLEAR, each edge:
    - If i_we=1, stall: no clear write, ptr and cnt hold.
    - Otherwise write mem[ptr]<=0, ptr<=ptr+1 (wraps modulo 2**ADDR_W), cnt<=cnt+1.
    - When cnt reaches len after the increment, go to DONE.
  - DONE: o_clr_done=1 for exactly one cycle, o_clr_busy=0, return to IDLE.
- i_clr_start while not in IDLE is ignored; the latched parameters do not change.
- len=2**ADDR_W clears the whole store.
- Reset mid-clear aborts immediately. Words already zeroed stay zero and the rest are untouched. No done pulse is produced.
- o_clr_busy is 1 in CLEAR only; it is 0 in IDLE and DONE.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults.
  - Clear FSM state encoding: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2.
  - Calculator read-latency constant RD_LAT=2, which the calculator capture pipeline uses as well.
- One natural sub-module, storage_clear_engine, containing the FSM, ptr, cnt and stall logic. It outputs a clear-write request (address, enable) to the top level, which muxes it behind the external write.

Test Plan:
1. Reset:
   - Hold rst_n=0 with random inputs -> o_rd_data=0, o_clr_busy=0, o_clr_done=0.
   - Release; present i_rd_addr=0 -> o_rd_data changes no earlier than 2 edges later.
2. Write then read:
   - Write mem[8'h10]=32'hDEADBEEF at edge 1.
   - Present i_rd_addr=8'h10 before edge 3 -> o_rd_data=32'hDEADBEEF after edge 4, and not after edge 3.
3. Bypass:
   - mem[5]=1.
   - Present addr 5 before edge k; write mem[5]=32'h7 at edge k+1 -> o_rd_data=7 after edge k+1.
4. Clear with stall and wrap:
   - Preload mem[250..255, 0..3]=32'hAAAA_AAAA.
   - Start clear, base=250, len=8; assert i_we to addr 100 on the 3rd CLEAR cycle.
   - Expected: o_clr_busy high for exactly 9 cycles, done pulse once, mem[250..255, 0..1]=0, mem[2..3]=32'hAAAA_AAAA, mem[100]=written value.
5. Zero length and ignored restart:
   - Clear with len=0 -> no busy cycle, done pulse 1 cycle after start, memory unchanged.
   - Second i_clr_start during a len=4 clear -> ignored; exactly 4 words cleared and one done pulse.
6. Reset mid-clear:
   - Clear base=0, len=16; assert rst_n=0 after 5 clear writes.
   - Expected: mem[0..4]=0, mem[5..15] unchanged, busy=0 and no done pulse after release.
